// File: rtl/mem_ram_dp.sv
// Dual-port (one write, one read) synchronous RAM with a post-reset clear sweep.
//
// After reset is released the block walks every address once, writing INIT_VAL,
// and reports BUSY for the 2^ADDR_W cycles this takes. Reads and writes are
// ignored while BUSY is high. Afterwards the block behaves as a simple RAM
// with a registered read port (1-cycle latency).
//
// Parameters:
//   DATA_W   - data word width in bits
//   ADDR_W   - address width; depth is 2^ADDR_W words
//   INIT_VAL - value written to every word by the clear sweep
//
// Ports:
//   CLOCK   in   single clock, rising edge
//   RESET_N in   synchronous active-low reset
//   WE      in   write enable
//   WADDR   in   write address
//   D       in   write data
//   RE      in   read enable
//   RADDR   in   read address
//   Q       out  registered read data (holds when no read is accepted)
//   Q_VALID out  high for one cycle after an accepted read
//   BUSY    out  high while the clear sweep runs (and during reset)
//
// Build option:
//   RAM_BYPASS_EN - when defined, a read and write to the same address in the
//                   same cycle return the new data D (write-through); when
//                   undefined, the old stored word is returned.

module mem_ram_dp #(
  parameter int unsigned        DATA_W   = 8,
  parameter int unsigned        ADDR_W   = 5,
  parameter logic [DATA_W-1:0]  INIT_VAL = '0
) (
  input  logic              CLOCK,
  input  logic              RESET_N,
  input  logic              WE,
  input  logic [ADDR_W-1:0] WADDR,
  input  logic [DATA_W-1:0] D,
  input  logic              RE,
  input  logic [ADDR_W-1:0] RADDR,
  output logic [DATA_W-1:0] Q,
  output logic              Q_VALID,
  output logic              BUSY
);

  localparam int unsigned Depth = 2 ** ADDR_W;

  typedef enum logic [0:0] {StClear, StReady} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0]   q_q, q_d;
  logic                q_valid_q, q_valid_d;
  logic [DATA_W-1:0]   mem [Depth];

  logic                ready;
  logic [DATA_W-1:0]   rd_word;

  assign ready = (state_q == StReady);

  // Same-address read-during-write selection.
  always_comb begin
    rd_word = mem[RADDR];
`ifdef RAM_BYPASS_EN
    if (WE && (WADDR == RADDR)) begin
      rd_word = D;
    end
`endif
  end

  // Next-state and read-path logic.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    q_d       = q_q;
    q_valid_d = 1'b0;
    unique case (state_q)
      StClear: begin
        cnt_d = cnt_q + ADDR_W'(1);
        // Last word written on this edge; the counter wraps to 0 as we leave.
        if (cnt_q == ADDR_W'(Depth - 1)) begin
          state_d = StReady;
        end
      end
      StReady: begin
        if (RE) begin
          q_d       = rd_word;
          q_valid_d = 1'b1;
        end
      end
      default: state_d = StClear;
    endcase
  end

  always_ff @(posedge CLOCK) begin
    if (!RESET_N) begin
      state_q   <= StClear;
      cnt_q     <= '0;
      q_q       <= '0;
      q_valid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      q_q       <= q_d;
      q_valid_q <= q_valid_d;
    end
  end

  // Storage array: no reset, and left untouched while RESET_N is low.
  always_ff @(posedge CLOCK) begin
    if (RESET_N) begin
      if (!ready) begin
        mem[cnt_q] <= INIT_VAL;
      end else if (WE) begin
        mem[WADDR] <= D;
      end
    end
  end

  assign Q       = q_q;
  assign Q_VALID = q_valid_q;
  assign BUSY    = ~ready;

endmodule

// File: tb/tb_mem_ram_dp.sv
// Self-checking bench for mem_ram_dp (default parameters).
// Reference model: a plain array of words plus the expected Q register value.

module tb_mem_ram_dp;

  localparam int DW = 8;
  localparam int AW = 5;
  localparam int N  = 32;

  logic          CLOCK = 1'b0;
  logic          RESET_N;
  logic          WE;
  logic [AW-1:0] WADDR;
  logic [DW-1:0] D;
  logic          RE;
  logic [AW-1:0] RADDR;
  logic [DW-1:0] Q;
  logic          Q_VALID;
  logic          BUSY;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] model [N];
  logic [DW-1:0] exp_q;

  mem_ram_dp #(.DATA_W(DW), .ADDR_W(AW), .INIT_VAL(8'h00)) dut (
    .CLOCK   (CLOCK),
    .RESET_N (RESET_N),
    .WE      (WE),
    .WADDR   (WADDR),
    .D       (D),
    .RE      (RE),
    .RADDR   (RADDR),
    .Q       (Q),
    .Q_VALID (Q_VALID),
    .BUSY    (BUSY)
  );

  always #5 CLOCK = ~CLOCK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Advance one edge; outputs are sampled 1 time unit after it.
  task automatic step();
    @(posedge CLOCK);
    #1;
  endtask

  task automatic idle();
    WE = 1'b0; RE = 1'b0; WADDR = '0; RADDR = '0; D = '0;
  endtask

  // Counts sweep cycles from the current point; expects 32.
  task automatic count_busy(input string tag);
    int n;
    n = 0;
    while (BUSY === 1'b1 && n < 100) begin
      check({tag, "_qv_busy"}, {31'b0, Q_VALID}, 32'd0);
      step();
      n++;
    end
    check(tag, n, N);
    for (int i = 0; i < N; i++) model[i] = 8'h00;
  endtask

  task automatic write(input int a, input logic [DW-1:0] v);
    WE = 1'b1; WADDR = AW'(a); D = v; RE = 1'b0;
    step();
    model[a] = v;
    WE = 1'b0;
  endtask

  task automatic read_chk(input string tag, input int a);
    RE = 1'b1; RADDR = AW'(a); WE = 1'b0;
    step();
    exp_q = model[a];
    check({tag, "_q"}, {24'b0, Q}, {24'b0, exp_q});
    check({tag, "_qv"}, {31'b0, Q_VALID}, 32'd1);
    RE = 1'b0;
  endtask

  initial begin
    logic          r_we, r_re;
    logic [AW-1:0] r_wa, r_ra;
    logic [DW-1:0] r_d;

    idle();
    RESET_N = 1'b0;
    exp_q = '0;

    // Reset held for two cycles.
    step();
    step();
    check("rst_busy", {31'b0, BUSY}, 32'd1);
    check("rst_q", {24'b0, Q}, 32'd0);
    check("rst_qv", {31'b0, Q_VALID}, 32'd0);

    // Sweep with a write attempt and reads that must be ignored.
    RESET_N = 1'b1;
    WE = 1'b1; WADDR = 5'd5; D = 8'hAA; RE = 1'b1; RADDR = 5'd5;
    count_busy("sweep_len");
    idle();
    check("sweep_q_hold", {24'b0, Q}, 32'd0);

    // Every word cleared (address 5 untouched by the locked-out write).
    for (int a = 0; a < N; a++) read_chk($sformatf("clr%0d", a), a);

    // Write 0x0F + 2n everywhere, read back.
    for (int a = 0; a < N; a++) write(a, DW'(8'h0F + 2 * a));
    for (int a = 0; a < N; a++) read_chk($sformatf("wr%0d", a), a);
    check("wr31_abs", {24'b0, Q}, 32'h4D);

    // Same-address collision.
    write(7, 8'h33);
    WE = 1'b1; RE = 1'b1; WADDR = 5'd7; RADDR = 5'd7; D = 8'h55;
    step();
`ifdef RAM_BYPASS_EN
    exp_q = 8'h55;
`else
    exp_q = 8'h33;
`endif
    model[7] = 8'h55;
    check("coll_q", {24'b0, Q}, {24'b0, exp_q});
    check("coll_qv", {31'b0, Q_VALID}, 32'd1);
    idle();
    read_chk("coll_after", 7);

    // Different-address simultaneous read and write.
    WE = 1'b1; RE = 1'b1; WADDR = 5'd9; D = 8'hC3; RADDR = 5'd2;
    step();
    model[9] = 8'hC3;
    check("diff_q", {24'b0, Q}, {24'b0, model[2]});
    idle();
    read_chk("diff_w", 9);

    // Hold behaviour.
    write(3, 8'h15);
    read_chk("hold_rd", 3);
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("hold_q%0d", i), {24'b0, Q}, 32'h15);
      check($sformatf("hold_qv%0d", i), {31'b0, Q_VALID}, 32'd0);
    end

    // Randomised traffic against the model.
    exp_q = Q === 8'h15 ? 8'h15 : 8'h15;
    for (int i = 0; i < 300; i++) begin
      r_we = 1'($urandom_range(0, 1));
      r_re = 1'($urandom_range(0, 1));
      r_wa = AW'($urandom_range(0, 7));
      r_ra = AW'($urandom_range(0, 7));
      r_d  = DW'($urandom);
      WE = r_we; RE = r_re; WADDR = r_wa; RADDR = r_ra; D = r_d;
      step();
      if (r_re) begin
`ifdef RAM_BYPASS_EN
        exp_q = (r_we && r_wa == r_ra) ? r_d : model[r_ra];
`else
        exp_q = model[r_ra];
`endif
      end
      if (r_we) model[r_wa] = r_d;
      check($sformatf("rnd%0d_q", i), {24'b0, Q}, {24'b0, exp_q});
      check($sformatf("rnd%0d_qv", i), {31'b0, Q_VALID}, {31'b0, r_re});
    end
    idle();

    // Mid-sweep reset, with a read in flight beforehand.
    RE = 1'b1; RADDR = 5'd1;
    RESET_N = 1'b0;
    step();
    step();
    RESET_N = 1'b1;
    idle();
    for (int i = 0; i < 10; i++) step();
    check("mid_busy10", {31'b0, BUSY}, 32'd1);
    RESET_N = 1'b0;
    RE = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      check($sformatf("mid_rst_q%0d", i), {24'b0, Q}, 32'd0);
      check($sformatf("mid_rst_qv%0d", i), {31'b0, Q_VALID}, 32'd0);
      check($sformatf("mid_rst_busy%0d", i), {31'b0, BUSY}, 32'd1);
    end
    RESET_N = 1'b1;
    idle();
    count_busy("mid_sweep_len");
    for (int a = 0; a < N; a += 5) read_chk($sformatf("mid_clr%0d", a), a);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
